// File: rtl/uart_tb_pkg.sv
// Shared definitions for the UART checker slice: sequencer state encoding
// and default widths.
package uart_tb_pkg;

    localparam int unsigned C_DATA_WIDTH      = 8;
    localparam int unsigned C_FIFO_ADDR_WIDTH = 4;
    localparam int unsigned C_GAP_WIDTH       = 16;
    localparam int unsigned C_TIMEOUT_WIDTH   = 24;
    localparam int unsigned C_COUNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } t_uart_seq_state;

endpackage

// File: rtl/tb_sync_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra bit so level and
// full fall out of a plain subtraction.
module tb_sync_fifo #(
    parameter int unsigned G_WIDTH      = 8,
    parameter int unsigned G_ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [G_WIDTH-1:0]    i_push_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [G_WIDTH-1:0]    o_pop_data,
    output logic [G_ADDR_WIDTH:0] o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned C_DEPTH = 1 << G_ADDR_WIDTH;
    localparam logic [G_ADDR_WIDTH:0] C_DEPTH_LVL = {1'b1, {G_ADDR_WIDTH{1'b0}}};

    logic [G_WIDTH-1:0]    r_mem [0:C_DEPTH-1];
    logic [G_ADDR_WIDTH:0] r_wptr;
    logic [G_ADDR_WIDTH:0] r_rptr;
    logic [G_ADDR_WIDTH:0] w_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_level   = r_wptr - r_rptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == C_DEPTH_LVL);
    assign o_empty   = (w_level == '0);
    // Flush dominates both ports; a full FIFO drops writes even when popping.
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign o_pop_data = r_mem[r_rptr[G_ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[G_ADDR_WIDTH-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Feeds queued bytes to tx_uart one frame at a time with a programmable
// inter-frame gap, a completion timeout, and sticky status.
module uart_tx_sequencer
    import uart_tb_pkg::*;
#(
    parameter int unsigned G_DATA_WIDTH      = C_DATA_WIDTH,
    parameter int unsigned G_FIFO_ADDR_WIDTH = C_FIFO_ADDR_WIDTH,
    parameter int unsigned G_GAP_WIDTH       = C_GAP_WIDTH,
    parameter int unsigned G_TIMEOUT_WIDTH   = C_TIMEOUT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [G_DATA_WIDTH-1:0]      i_wr_data,
    input  logic                         i_flush,
    input  logic                         i_enable,
    input  logic [G_GAP_WIDTH-1:0]       i_gap_cycles,
    input  logic [G_TIMEOUT_WIDTH-1:0]   i_timeout_cycles,
    input  logic                         i_clr_status,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [G_FIFO_ADDR_WIDTH:0]   o_level,
    output logic                         o_start_tx,
    output logic [G_DATA_WIDTH-1:0]      o_tx_data,
    input  logic                         i_tx_done,
    output logic                         o_busy,
    output logic [C_COUNT_WIDTH-1:0]     o_tx_count,
    output logic                         o_overflow,
    output logic                         o_timeout
);

    t_uart_seq_state              r_state;
    logic                         r_done_d;
    logic                         r_start_tx;
    logic [G_DATA_WIDTH-1:0]      r_tx_data;
    logic [G_GAP_WIDTH-1:0]       r_gap_cnt;
    logic [G_TIMEOUT_WIDTH-1:0]   r_to_cnt;
    logic [C_COUNT_WIDTH-1:0]     r_tx_count;
    logic                         r_overflow;
    logic                         r_timeout;

    logic [G_DATA_WIDTH-1:0]      w_fifo_data;
    logic                         w_launch;
    logic                         w_done_rise;
    logic [G_TIMEOUT_WIDTH-1:0]   w_to_next;
    logic                         w_to_hit;
    logic                         w_count_inc;
    logic                         w_ovf;

    tb_sync_fifo #(
        .G_WIDTH      (G_DATA_WIDTH),
        .G_ADDR_WIDTH (G_FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (i_wr_en),
        .i_push_data (i_wr_data),
        .i_pop       (w_launch),
        .i_flush     (i_flush),
        .o_pop_data  (w_fifo_data),
        .o_level     (o_level),
        .o_full      (o_full),
        .o_empty     (o_empty)
    );

    assign w_launch    = (r_state == S_IDLE) & i_enable & ~o_empty & ~i_flush;
    assign w_done_rise = i_tx_done & ~r_done_d;
    assign w_count_inc = (r_state == S_WAIT_DONE) & w_done_rise;
    // Compare against count+1 so the flag lands exactly i_timeout_cycles after entry.
    assign w_to_next   = r_to_cnt + G_TIMEOUT_WIDTH'(1);
    assign w_to_hit    = (r_state == S_WAIT_DONE) & ~w_done_rise
                       & (i_timeout_cycles != '0) & (w_to_next == i_timeout_cycles);
    assign w_ovf       = i_wr_en & o_full & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_done_d   <= 1'b0;
            r_start_tx <= 1'b0;
            r_tx_data  <= '0;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
            r_tx_count <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done_d   <= i_tx_done;
            r_start_tx <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_tx_data  <= w_fifo_data;
                        r_start_tx <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (w_done_rise) begin
                        if (i_gap_cycles == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap_cnt <= i_gap_cycles;
                            r_state   <= S_GAP;
                        end
                    end else if (w_to_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt <= G_GAP_WIDTH'(1)) r_state <= S_IDLE;
                    else r_gap_cnt <= r_gap_cnt - G_GAP_WIDTH'(1);
                end
                default: r_state <= S_IDLE;
            endcase

            if (i_clr_status) begin
                r_tx_count <= '0;
                r_overflow <= 1'b0;
                r_timeout  <= 1'b0;
            end else begin
                if (w_count_inc) r_tx_count <= r_tx_count + 16'd1;
                if (w_ovf)       r_overflow <= 1'b1;
                if (w_to_hit)    r_timeout  <= 1'b1;
            end
        end
    end

    assign o_start_tx = r_start_tx;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = (r_state != S_IDLE);
    assign o_tx_count = r_tx_count;
    assign o_overflow = r_overflow;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer; the bench plays the tx_uart side
// by driving i_tx_done by hand.
module tb_uart_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wr_en;
    logic [7:0]  i_wr_data;
    logic        i_flush;
    logic        i_enable;
    logic [15:0] i_gap_cycles;
    logic [23:0] i_timeout_cycles;
    logic        i_clr_status;
    logic        o_full;
    logic        o_empty;
    logic [4:0]  o_level;
    logic        o_start_tx;
    logic [7:0]  o_tx_data;
    logic        i_tx_done;
    logic        o_busy;
    logic [15:0] o_tx_count;
    logic        o_overflow;
    logic        o_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .G_DATA_WIDTH      (8),
        .G_FIFO_ADDR_WIDTH (4),
        .G_GAP_WIDTH       (16),
        .G_TIMEOUT_WIDTH   (24)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_wr_en          (i_wr_en),
        .i_wr_data        (i_wr_data),
        .i_flush          (i_flush),
        .i_enable         (i_enable),
        .i_gap_cycles     (i_gap_cycles),
        .i_timeout_cycles (i_timeout_cycles),
        .i_clr_status     (i_clr_status),
        .o_full           (o_full),
        .o_empty          (o_empty),
        .o_level          (o_level),
        .o_start_tx       (o_start_tx),
        .o_tx_data        (o_tx_data),
        .i_tx_done        (i_tx_done),
        .o_busy           (o_busy),
        .o_tx_count       (o_tx_count),
        .o_overflow       (o_overflow),
        .o_timeout        (o_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int dt);
        dt = 0;
        while (!o_start_tx && dt < limit) begin
            tick();
            dt++;
        end
    endtask

    // One-cycle done pulse, then cycles until the next launch (capped at limit).
    task automatic do_done(input int limit, output int dt);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        dt = 1;
        while (!o_start_tx && dt < limit) begin
            tick();
            dt++;
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_empty"},    32'(o_empty),    32'd1);
        chk({pfx, "_full"},     32'(o_full),     32'd0);
        chk({pfx, "_level"},    32'(o_level),    32'd0);
        chk({pfx, "_start"},    32'(o_start_tx), 32'd0);
        chk({pfx, "_data"},     32'(o_tx_data),  32'd0);
        chk({pfx, "_busy"},     32'(o_busy),     32'd0);
        chk({pfx, "_count"},    32'(o_tx_count), 32'd0);
        chk({pfx, "_overflow"}, 32'(o_overflow), 32'd0);
        chk({pfx, "_timeout"},  32'(o_timeout),  32'd0);
    endtask

    initial begin
        int dt;
        int seen;

        rst = 1'b1; i_wr_en = 1'b0; i_wr_data = '0; i_flush = 1'b0;
        i_enable = 1'b0; i_gap_cycles = '0; i_timeout_cycles = '0;
        i_clr_status = 1'b0; i_tx_done = 1'b0;
        tick();
        tick();
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Single byte, gap 0
        i_enable = 1'b1;
        write_byte(8'hA5);
        chk("sb_level_c1", 32'(o_level), 32'd1);
        chk("sb_start_c1", 32'(o_start_tx), 32'd0);
        tick();
        chk("sb_start_c2", 32'(o_start_tx), 32'd1);
        chk("sb_data_c2", 32'(o_tx_data), 32'hA5);
        chk("sb_busy_c2", 32'(o_busy), 32'd1);
        chk("sb_level_c2", 32'(o_level), 32'd0);
        tick();
        chk("sb_start_c3", 32'(o_start_tx), 32'd0);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("sb_count", 32'(o_tx_count), 32'd1);
        chk("sb_idle", 32'(o_busy), 32'd0);

        // Burst of four with gap 10
        do_reset();
        i_enable = 1'b0;
        i_gap_cycles = 16'd10;
        for (int i = 1; i <= 4; i++) write_byte(8'(i));
        i_enable = 1'b1;
        wait_start(10, dt);
        chk("bu_first_start", 32'(o_start_tx), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("bu_data%0d", i), 32'(o_tx_data), 32'(i));
            tick();
            if (i < 4) begin
                do_done(40, dt);
                chk($sformatf("bu_spacing%0d", i), 32'(dt), 32'd12);
            end
        end
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        repeat (9) tick();
        chk("bu_last_gap_busy", 32'(o_busy), 32'd1);
        tick();
        chk("bu_idle_after_gap", 32'(o_busy), 32'd0);
        chk("bu_count", 32'(o_tx_count), 32'd4);
        chk("bu_empty", 32'(o_empty), 32'd1);

        // Overflow: 17 writes into 16 entries
        do_reset();
        i_enable = 1'b0;
        i_gap_cycles = '0;
        for (int i = 0; i < 17; i++) write_byte(8'(i));
        chk("ov_full", 32'(o_full), 32'd1);
        chk("ov_level", 32'(o_level), 32'd16);
        chk("ov_flag", 32'(o_overflow), 32'd1);
        i_enable = 1'b1;
        wait_start(10, dt);
        chk("ov_first_start", 32'(o_start_tx), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ov_data%0d", i), 32'(o_tx_data), 32'(i));
            tick();
            if (i < 15) begin
                do_done(10, dt);
                chk($sformatf("ov_spacing%0d", i), 32'(dt), 32'd2);
            end
        end
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (o_start_tx) seen = 1;
        end
        chk("ov_no_17th", 32'(seen), 32'd0);
        chk("ov_count", 32'(o_tx_count), 32'd16);
        chk("ov_sticky", 32'(o_overflow), 32'd1);

        // Timeout of 100 cycles
        do_reset();
        i_enable = 1'b0;
        i_timeout_cycles = 24'd100;
        write_byte(8'h11);
        write_byte(8'h22);
        i_enable = 1'b1;
        wait_start(10, dt);
        chk("to_data1", 32'(o_tx_data), 32'h11);
        repeat (100) tick();
        chk("to_not_yet", 32'(o_timeout), 32'd0);
        tick();
        chk("to_flag", 32'(o_timeout), 32'd1);
        chk("to_count", 32'(o_tx_count), 32'd0);
        chk("to_idle", 32'(o_busy), 32'd0);
        tick();
        chk("to_next_start", 32'(o_start_tx), 32'd1);
        chk("to_next_data", 32'(o_tx_data), 32'h22);
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("to_count_after", 32'(o_tx_count), 32'd1);
        chk("to_still_sticky", 32'(o_timeout), 32'd1);
        i_clr_status = 1'b1;
        tick();
        i_clr_status = 1'b0;
        chk("clr_timeout", 32'(o_timeout), 32'd0);
        chk("clr_count", 32'(o_tx_count), 32'd0);

        // Flush during the first frame
        do_reset();
        i_enable = 1'b0;
        i_timeout_cycles = '0;
        for (int i = 0; i < 5; i++) write_byte(8'(8'h30 + i));
        chk("fl_level5", 32'(o_level), 32'd5);
        i_enable = 1'b1;
        wait_start(10, dt);
        chk("fl_data", 32'(o_tx_data), 32'h30);
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("fl_empty", 32'(o_empty), 32'd1);
        chk("fl_busy", 32'(o_busy), 32'd1);
        do_done(30, dt);
        chk("fl_no_launch", 32'(dt), 32'd30);
        chk("fl_count", 32'(o_tx_count), 32'd1);
        chk("fl_idle", 32'(o_busy), 32'd0);

        // Enable dropped mid-frame
        write_byte(8'h55);
        write_byte(8'h66);
        wait_start(10, dt);
        chk("en_data", 32'(o_tx_data), 32'h55);
        i_enable = 1'b0;
        tick();
        do_done(30, dt);
        chk("en_no_launch", 32'(dt), 32'd30);
        chk("en_count", 32'(o_tx_count), 32'd2);
        chk("en_level", 32'(o_level), 32'd1);

        // Reset while waiting for done
        i_enable = 1'b1;
        wait_start(10, dt);
        chk("rw_data", 32'(o_tx_data), 32'h66);
        tick();
        chk("rw_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("rw");
        rst = 1'b0;
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        tick();
        chk("rw_done_ignored", 32'(o_tx_count), 32'd0);
        chk("rw_stays_idle", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
